// File: rtl/mul_controller.sv
// Control FSM for the 4-bit shift-add multiplier datapath; optional sticky start-while-busy flag under MUL_CTRL_START_ERR_EN.
// Latency: accept at T, done_o at T+10, product_o valid from T+11; initiation interval 11 cycles.
// Backpressure: ready_o is high only in IDLE; start_i at any other time is ignored.
module mul_controller #(
    parameter int WIDTH  = 4,
    parameter int PWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  opa_i,
    input  logic [WIDTH-1:0]  opb_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [PWIDTH-1:0] product_o,
    output logic              err_o,
    output logic [WIDTH-1:0]  multplcnd_o,
    output logic [WIDTH-1:0]  multplr_o,
    output logic              load_reg_o,
    output logic              add_o,
    output logic              mux_ctrl_o,
    output logic              shift_ena_o,
    input  logic              multplr_lsb_i,
    input  logic [1:0]        step_count_i,
    input  logic [PWIDTH-1:0] acc_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ADD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic accept;

    assign accept = start_i && (state_q == ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands are held through the whole operation so the datapath sees them stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            multplcnd_o <= '0;
            multplr_o   <= '0;
        end else if (accept) begin
            multplcnd_o <= opa_i;
            multplr_o   <= opb_i;
        end
    end

    // acc_i already includes the 4th shift when the FSM reaches DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            product_o <= '0;
        end else if (state_q == ST_DONE) begin
            product_o <= acc_i;
        end
    end

`ifdef MUL_CTRL_START_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (start_i && !ready_o) begin
            err_o <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ready_o     = 1'b0;
        done_o      = 1'b0;
        load_reg_o  = 1'b0;
        add_o       = 1'b0;
        mux_ctrl_o  = 1'b0;
        shift_ena_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_reg_o = 1'b1;
                state_d    = ST_ADD;
            end
            ST_ADD: begin
                add_o      = 1'b1;
                mux_ctrl_o = multplr_lsb_i;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_ena_o = 1'b1;
                // Counter is sampled before this shift decrements it.
                if (step_count_i == 2'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_controller.sv
// Directed bench for mul_controller with a behavioural shift-add datapath closing the loop.
module tb_mul_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] opa;
    logic [3:0] opb;
    logic       ready;
    logic       done;
    logic [7:0] product;
    logic       err;
    logic [3:0] multplcnd;
    logic [3:0] multplr;
    logic       load_reg;
    logic       add;
    logic       mux_ctrl;
    logic       shift_ena;

    logic [7:0] dp_acc   = 8'h00;
    logic       dp_carry = 1'b0;
    logic [1:0] dp_cnt   = 2'd0;

    int checks = 0;
    int errors = 0;
    logic err_exp;

    always #5 clk = ~clk;

    mul_controller dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .opa_i        (opa),
        .opb_i        (opb),
        .ready_o      (ready),
        .done_o       (done),
        .product_o    (product),
        .err_o        (err),
        .multplcnd_o  (multplcnd),
        .multplr_o    (multplr),
        .load_reg_o   (load_reg),
        .add_o        (add),
        .mux_ctrl_o   (mux_ctrl),
        .shift_ena_o  (shift_ena),
        .multplr_lsb_i(dp_acc[0]),
        .step_count_i (dp_cnt),
        .acc_i        (dp_acc)
    );

    // Datapath: upper nibble accumulates with carry, whole register shifts right.
    always @(posedge clk) begin
        if (rst) begin
            dp_acc   <= 8'h00;
            dp_carry <= 1'b0;
            dp_cnt   <= 2'd0;
        end else if (load_reg) begin
            dp_acc   <= {4'h0, multplr};
            dp_carry <= 1'b0;
            dp_cnt   <= 2'd3;
        end else if (add) begin
            {dp_carry, dp_acc[7:4]} <= {1'b0, dp_acc[7:4]} + (mux_ctrl ? {1'b0, multplcnd} : 5'd0);
        end else if (shift_ena) begin
            dp_acc   <= {dp_carry, dp_acc[7:1]};
            dp_carry <= 1'b0;
            dp_cnt   <= dp_cnt - 2'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in a cycle where ready is expected high; returns in cycle T+11.
    // inject > 0 raises start with 2*2 during that cycle offset from T.
    task automatic run_mul(input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp_prod, input int inject);
        check_eq("accept_ready", ready, 8'd1);
        start = 1'b1;
        opa   = a;
        opb   = b;
        for (int c = 1; c <= 11; c++) begin
            step();
            start = (c == inject);
            if (c == inject) begin
                opa = 4'd2;
                opb = 4'd2;
            end
            check_eq("ready", ready, 8'(c == 11));
            check_eq("done", done, 8'(c == 10));
            check_eq("load", load_reg, 8'(c == 1));
            check_eq("add", add, 8'(c >= 2 && c <= 8 && c % 2 == 0));
            check_eq("shift", shift_ena, 8'(c >= 3 && c <= 9 && c % 2 == 1));
            if (c >= 2 && c <= 8 && c % 2 == 0)
                check_eq("mux_add", mux_ctrl, 8'(b[(c - 2) / 2]));
            else
                check_eq("mux_idle", mux_ctrl, 8'd0);
            if (c == 1 || c == 6) begin
                check_eq("mcand", 8'(multplcnd), 8'(a));
                check_eq("mplr", 8'(multplr), 8'(b));
            end
        end
        check_eq("product", product, exp_prod);
        start = 1'b0;
    endtask

    initial begin
`ifdef MUL_CTRL_START_ERR_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        rst   = 1'b1;
        start = 1'b0;
        opa   = 4'd0;
        opb   = 4'd0;
        repeat (3) step();
        check_eq("rst_ready", ready, 8'd1);
        check_eq("rst_done", done, 8'd0);
        check_eq("rst_product", product, 8'h00);
        check_eq("rst_err", err, 8'd0);
        check_eq("rst_strobes", {5'd0, load_reg, add, shift_ena}, 8'd0);
        check_eq("rst_mux", mux_ctrl, 8'd0);
        check_eq("rst_mcand", 8'(multplcnd), 8'h00);
        check_eq("rst_mplr", 8'(multplr), 8'h00);
        rst = 1'b0;
        step();

        run_mul(4'd13, 4'd11, 8'h8F, 0);
        step();
        run_mul(4'd0, 4'd15, 8'h00, 0);
        run_mul(4'd15, 4'd0, 8'h00, 0);
        run_mul(4'd15, 4'd15, 8'hE1, 0);
        check_eq("err_clean", err, 8'd0);

        run_mul(4'd9, 4'd7, 8'h3F, 5);
        check_eq("err_busy_start", err, 8'(err_exp));
        step();
        check_eq("product_hold", product, 8'h3F);

        // Abort 6*5 with a reset pulse during cycle T+4.
        start = 1'b1;
        opa   = 4'd6;
        opb   = 4'd5;
        for (int c = 1; c <= 4; c++) begin
            step();
            start = 1'b0;
            rst   = (c == 4);
        end
        step();
        rst = 1'b0;
        check_eq("abort_ready", ready, 8'd1);
        check_eq("abort_done", done, 8'd0);
        check_eq("abort_product", product, 8'h00);
        check_eq("abort_err", err, 8'd0);
        check_eq("abort_strobes", {5'd0, load_reg, add, shift_ena}, 8'd0);
        for (int c = 0; c < 8; c++) begin
            step();
            check_eq("abort_no_done", done, 8'd0);
        end
        run_mul(4'd3, 4'd3, 8'h09, 0);

        step();
        run_mul(4'd4, 4'd4, 8'h10, 0);
        run_mul(4'd5, 4'd3, 8'h0F, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_controller.md
Name: mul_controller

Overview:
- Control FSM that sits directly upstream of the 4-bit shift-add multiplier datapath (mul_datapath).
- Accepts operand pairs over a start/ready handshake and captures them.
- Sequences the datapath's load, add and shift strobes, then registers the 8-bit product and pulses done.
- One multiplication in flight at a time.

Parameters:
- WIDTH, 4, operand width. Only 4 is supported, matching the datapath's 2-bit step counter.
- PWIDTH, 8, product width (2*WIDTH).

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request a multiply; accepted when start_i && ready_o
- opa_i  input  4  multiplicand, sampled on accept
- opb_i  input  4  multiplier, sampled on accept
- ready_o  output  1  high only in IDLE
- done_o  output  1  one-cycle pulse when product_o is updated
- product_o  output  8  registered product of last completed multiply
- err_o  output  1  sticky start-while-busy flag (see Optional Feature)
- multplcnd_o  output  4  captured multiplicand to datapath
- multplr_o  output  4  captured multiplier to datapath
- load_reg_o  output  1  datapath load strobe
- add_o  output  1  datapath add strobe
- mux_ctrl_o  output  1  datapath add-select (1 = add multiplicand, 0 = add zero)
- shift_ena_o  output  1  datapath shift strobe
- multplr_lsb_i  input  1  datapath current multiplier LSB
- step_count_i  input  2  datapath step counter (3 after load, decrements on each shift)
- acc_i  input  8  datapath product/accumulator view

Behaviour:
- Reset: state=IDLE; product_o=0, done_o=0, err_o=0, multplcnd_o=0, multplr_o=0. All strobes low, ready_o=1.
- Reset mid-operation: abandon the operation, return to IDLE next cycle. product_o is cleared; no done_o pulse.
- States: IDLE, LOAD, ADD, SHIFT, DONE. State is registered.
- Strobes and ready_o are decoded combinationally from the state register (Moore).
- Exactly one of load_reg_o/add_o/shift_ena_o is high in LOAD/ADD/SHIFT; all three are low in IDLE and DONE.
- IDLE:
  - ready_o=1.
  - On start_i: capture opa_i into multplcnd_o and opb_i into multplr_o; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: load_reg_o=1 → ADD. The captured operands are stable on multplcnd_o/multplr_o during this cycle.
- ADD: add_o=1, mux_ctrl_o=multplr_lsb_i → SHIFT.
- SHIFT:
  - shift_ena_o=1.
  - If step_count_i==0 (the pre-decrement value seen this cycle): this is the 4th shift → DONE.
  - Else → ADD.
- DONE:
  - product_o<=acc_i (the value after the 4th shift) and done_o=1 for this cycle, then → IDLE.
  - ready_o=0; start_i is ignored in this cycle.
- mux_ctrl_o is 0 outside ADD.
- Latency: accept at cycle T → LOAD T+1 → four ADD/SHIFT pairs T+2..T+9 → DONE T+10 (done_o high, product_o valid from T+11).
- Back-to-back: the next accept is possible at T+11, giving an initiation interval of 11 cycles.
- Arithmetic: the result is the unsigned 4x4 → 8-bit product. No overflow is possible; 15*15=225 fits in 8 bits.
- start_i while ready_o=0 is ignored: no state change, operands not re-captured.
- Operand inputs are don't-care outside the accept cycle.
- product_o holds its value until the next DONE or reset.

Optional Feature:
- Macro MUL_CTRL_START_ERR_EN.
- Defined:
  - err_o sets when start_i=1 and ready_o=0 in the same cycle.
  - It stays set until rst_i; it has no effect on sequencing.
- Undefined: err_o is tied to 0 and the detection logic is not built. The port list is identical in both builds.

Test Plan:
- Reset, then start_i with opa=13, opb=11 for one cycle → load strobe at T+1, four add/shift pairs, done_o at T+10, product_o=0x8F (143).
- opa=0, opb=15, and separately opa=15, opb=0 → product_o=0x00. mux_ctrl_o=1 on all four adds for opb=15 and 0 on all four for opb=0.
- opa=15, opb=15 → product_o=0xE1 (225), exercising the accumulator carry.
- Start 9*7, then pulse start_i with opa=2, opb=2 at T+5 → ignored; product_o=0x3F, ready_o low until T+11. err_o=1 only with MUL_CTRL_START_ERR_EN defined, 0 without.
- Start 6*5, assert rst_i at T+4 for one cycle → IDLE next cycle, no done_o, product_o=0, err_o=0. A following start 3*3 completes with product_o=0x09.
- Back-to-back: 4*4 accepted at T, 5*3 accepted at T+11 → done_o at T+10 (0x10) and T+21 (0x0F).
